debug_axi_uart: RTL and testbench

- UART-controlled debug master for an AXI4 bus: a host sends byte commands on rxd; the block performs single-beat 32-bit AXI reads/writes and returns status/data on txd.
- Sits between a debug UART pin pair and an AXI interconnect master port, for bring-up and register poking.

---
 rtl/debug_axi_uart.sv | 344 ++++++++++++++++++++++++++++++++++
 tb/tb_debug_axi_uart.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_axi_uart.sv
// UART-controlled AXI4 debug master: 'W'/'R' byte commands on rxd become single-beat
// 32-bit AXI accesses, and status plus read data are returned on txd.
module debug_axi_uart #(
    parameter int unsigned CLK_DIV = 16,
    parameter int unsigned AXI_ID  = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    output logic        txd,
    output logic [31:0] awaddr,
    output logic [3:0]  awid,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready,
    output logic [31:0] araddr,
    output logic [3:0]  arid,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [3:0]  rid,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    localparam int unsigned CW   = $clog2(CLK_DIV + 1);
    localparam int unsigned HALF = CLK_DIV / 2;

    typedef enum logic [2:0] {RX_ARM, RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {P_IDLE, P_COLLECT, P_WR, P_B, P_AR, P_R, P_TX} p_state_t;

    assign awid    = 4'(AXI_ID);
    assign arid    = 4'(AXI_ID);
    assign awlen   = 8'd0;
    assign arlen   = 8'd0;
    assign awsize  = 3'b010;
    assign arsize  = 3'b010;
    assign awburst = 2'b01;
    assign arburst = 2'b01;
    assign wstrb   = 4'hF;
    assign wlast   = 1'b1;

    logic unused_inputs;
    assign unused_inputs = ^{bid, rid, rlast};

    logic            rx_s1_q, rx_s2_q;
    rx_state_t       rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bits_q, rx_bits_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            rx_valid_q, rx_valid_d;
    logic            rx_err_q, rx_err_d;

    p_state_t        p_state_q, p_state_d;
    logic [63:0]     sh_q, sh_d;
    logic [3:0]      byte_cnt_q, byte_cnt_d;
    logic            is_wr_q, is_wr_d;
    logic [31:0]     awaddr_q, awaddr_d, wdata_q, wdata_d, araddr_q, araddr_d;
    logic            awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic            arvalid_q, arvalid_d, rready_q, rready_d;
    logic            txd_q, txd_d;
    logic [39:0]     tx_buf_q, tx_buf_d;
    logic [2:0]      tx_left_q, tx_left_d;
    logic [8:0]      tx_frame_q, tx_frame_d;
    logic [3:0]      tx_bit_q, tx_bit_d;
    logic [CW-1:0]   tx_cyc_q, tx_cyc_d;
    logic            tx_go;
    logic [39:0]     tx_load;
    logic [2:0]      tx_n;
    logic            aw_done, w_done;

    assign txd     = txd_q;
    assign awaddr  = awaddr_q;
    assign wdata   = wdata_q;
    assign araddr  = araddr_q;
    assign awvalid = awvalid_q;
    assign wvalid  = wvalid_q;
    assign bready  = bready_q;
    assign arvalid = arvalid_q;
    assign rready  = rready_q;

    // Receiver: arm on a full bit-time of idle, mid-bit sampling, glitch and framing checks.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bits_d  = rx_bits_q;
        rx_shift_d = rx_shift_q;
        rx_valid_d = 1'b0;
        rx_err_d   = 1'b0;
        case (rx_state_q)
            RX_ARM: begin
                if (!rx_s2_q) begin
                    rx_cnt_d = '0;
                end else if (rx_cnt_q == CW'(CLK_DIV - 1)) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RX_IDLE: begin
                if (!rx_s2_q) begin
                    rx_cnt_d   = CW'(1);
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt_q == CW'(HALF)) begin
                    if (rx_s2_q) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_cnt_d   = CW'(1);
                        rx_bits_d  = '0;
                        rx_state_d = RX_DATA;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == CW'(CLK_DIV)) begin
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    rx_cnt_d   = CW'(1);
                    rx_bits_d  = rx_bits_q + 3'd1;
                    if (rx_bits_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == CW'(CLK_DIV)) begin
                    rx_cnt_d = '0;
                    if (rx_s2_q) begin
                        rx_valid_d = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_err_d   = 1'b1;
                        rx_state_d = RX_ARM;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            default: rx_state_d = RX_ARM;
        endcase
    end

    // Command parser, AXI sequencing and reply transmitter.
    always_comb begin
        p_state_d  = p_state_q;
        sh_d       = sh_q;
        byte_cnt_d = byte_cnt_q;
        is_wr_d    = is_wr_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        araddr_d   = araddr_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        bready_d   = bready_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        txd_d      = txd_q;
        tx_buf_d   = tx_buf_q;
        tx_left_d  = tx_left_q;
        tx_frame_d = tx_frame_q;
        tx_bit_d   = tx_bit_q;
        tx_cyc_d   = tx_cyc_q;
        tx_go      = 1'b0;
        tx_load    = '0;
        tx_n       = '0;
        aw_done    = !awvalid_q || awready;
        w_done     = !wvalid_q || wready;
        case (p_state_q)
            P_IDLE: begin
                if (rx_valid_q && (rx_shift_q == 8'h57 || rx_shift_q == 8'h52)) begin
                    is_wr_d    = (rx_shift_q == 8'h57);
                    byte_cnt_d = '0;
                    p_state_d  = P_COLLECT;
                end
            end
            P_COLLECT: begin
                if (rx_err_q) begin
                    p_state_d = P_IDLE;
                end else if (rx_valid_q) begin
                    sh_d       = {sh_q[55:0], rx_shift_q};
                    byte_cnt_d = byte_cnt_q + 4'd1;
                    if (is_wr_q && byte_cnt_q == 4'd7) begin
                        awaddr_d  = sh_q[55:24];
                        wdata_d   = {sh_q[23:0], rx_shift_q};
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        p_state_d = P_WR;
                    end else if (!is_wr_q && byte_cnt_q == 4'd3) begin
                        araddr_d  = {sh_q[23:0], rx_shift_q};
                        arvalid_d = 1'b1;
                        p_state_d = P_AR;
                    end
                end
            end
            P_WR: begin
                if (awvalid_q && awready) awvalid_d = 1'b0;
                if (wvalid_q && wready)   wvalid_d  = 1'b0;
                if (aw_done && w_done) begin
                    bready_d  = 1'b1;
                    p_state_d = P_B;
                end
            end
            P_B: begin
                if (bvalid) begin
                    bready_d = 1'b0;
                    tx_go    = 1'b1;
                    tx_load  = {(bresp == 2'b00) ? 8'h4B : 8'h45, 32'h0};
                    tx_n     = 3'd1;
                end
            end
            P_AR: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    p_state_d = P_R;
                end
            end
            P_R: begin
                if (rvalid) begin
                    rready_d = 1'b0;
                    tx_go    = 1'b1;
                    tx_load  = {(rresp == 2'b00) ? 8'h4B : 8'h45, rdata};
                    tx_n     = 3'd5;
                end
            end
            P_TX: begin
                if (tx_cyc_q == CW'(CLK_DIV - 1)) begin
                    tx_cyc_d = '0;
                    if (tx_bit_q == 4'd9) begin
                        if (tx_left_q != 3'd0) begin
                            tx_frame_d = {1'b1, tx_buf_q[39:32]};
                            tx_buf_d   = {tx_buf_q[31:0], 8'h00};
                            tx_left_d  = tx_left_q - 3'd1;
                            tx_bit_d   = '0;
                            txd_d      = 1'b0;
                        end else begin
                            txd_d     = 1'b1;
                            p_state_d = P_IDLE;
                        end
                    end else begin
                        txd_d      = tx_frame_q[0];
                        tx_frame_d = {1'b1, tx_frame_q[8:1]};
                        tx_bit_d   = tx_bit_q + 4'd1;
                    end
                end else begin
                    tx_cyc_d = tx_cyc_q + CW'(1);
                end
            end
            default: p_state_d = P_IDLE;
        endcase
        // The start bit of the first reply byte goes out on the same edge the response is taken.
        if (tx_go) begin
            tx_frame_d = {1'b1, tx_load[39:32]};
            tx_buf_d   = {tx_load[31:0], 8'h00};
            tx_left_d  = tx_n - 3'd1;
            tx_bit_d   = '0;
            tx_cyc_d   = '0;
            txd_d      = 1'b0;
            p_state_d  = P_TX;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_state_q <= RX_ARM;
            rx_cnt_q   <= '0;
            rx_bits_q  <= '0;
            rx_shift_q <= '0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
            p_state_q  <= P_IDLE;
            sh_q       <= '0;
            byte_cnt_q <= '0;
            is_wr_q    <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            araddr_q   <= '0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            txd_q      <= 1'b1;
            tx_buf_q   <= '0;
            tx_left_q  <= '0;
            tx_frame_q <= '1;
            tx_bit_q   <= '0;
            tx_cyc_q   <= '0;
        end else begin
            rx_s1_q    <= rxd;
            rx_s2_q    <= rx_s1_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bits_q  <= rx_bits_d;
            rx_shift_q <= rx_shift_d;
            rx_valid_q <= rx_valid_d;
            rx_err_q   <= rx_err_d;
            p_state_q  <= p_state_d;
            sh_q       <= sh_d;
            byte_cnt_q <= byte_cnt_d;
            is_wr_q    <= is_wr_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            araddr_q   <= araddr_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            bready_q   <= bready_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            txd_q      <= txd_d;
            tx_buf_q   <= tx_buf_d;
            tx_left_q  <= tx_left_d;
            tx_frame_q <= tx_frame_d;
            tx_bit_q   <= tx_bit_d;
            tx_cyc_q   <= tx_cyc_d;
        end
    end

endmodule

// File: tb/tb_debug_axi_uart.sv
// Randomized self-checking bench: UART host driver, reactive AXI slave and a UART
// decoder on txd, checked against replies/addresses derived from the command bytes.
module tb_debug_axi_uart;

    localparam int unsigned N = 8;

    logic        clk = 1'b0;
    logic        rst, rxd, txd;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  awid, arid, wstrb, bid, rid;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;

    debug_axi_uart #(.CLK_DIV(N), .AXI_ID(5)) dut (
        .clk(clk), .rst(rst), .rxd(rxd), .txd(txd),
        .awaddr(awaddr), .awid(awid), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rid(rid), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Slave configuration and observations
    int          aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
    logic [1:0]  cfg_bresp = 0, cfg_rresp = 0;
    logic [31:0] cfg_rdata = 0;
    bit          abort_ok = 0;
    logic [31:0] got_awaddr = 0, got_wdata = 0, got_araddr = 0;
    logic [16:0] got_aw_misc = 0;
    logic [4:0]  got_w_misc = 0;
    int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    int unsigned aw_hs_cyc = 0, w_hs_cyc = 0, bready_cyc = 0;
    bit          aw_done = 0, w_done = 0, w_saw_aw = 0;
    int          proto_err = 0, tx_err = 0;
    logic [7:0]  tx_q[$];
    int unsigned tx_t[$];

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // AW channel: hold off awready for aw_delay cycles, valid must not drop meanwhile.
    initial begin
        awready = 0;
        forever begin
            @(posedge clk); #1;
            if (awvalid) begin
                for (int i = 0; i < aw_delay && awvalid; i++) begin @(posedge clk); #1; end
                if (awvalid) begin
                    awready = 1; got_awaddr = awaddr; got_aw_misc = {awid, awlen, awsize, awburst};
                    @(posedge clk); #1;
                    awready = 0; aw_hs_cyc = cyc; aw_cnt++; aw_done = 1;
                    if (awvalid) proto_err++;
                end else if (!abort_ok) proto_err++;
            end
        end
    end

    initial begin
        wready = 0;
        forever begin
            @(posedge clk); #1;
            if (wvalid) begin
                for (int i = 0; i < w_delay && wvalid; i++) begin @(posedge clk); #1; end
                if (wvalid) begin
                    wready = 1; got_wdata = wdata; got_w_misc = {wstrb, wlast};
                    @(posedge clk); #1;
                    wready = 0; w_hs_cyc = cyc; w_cnt++; w_done = 1; w_saw_aw = awvalid;
                    if (wvalid) proto_err++;
                end else if (!abort_ok) proto_err++;
            end
        end
    end

    initial begin
        bvalid = 0; bresp = 0; bid = 0;
        forever begin
            @(posedge clk); #1;
            if (bready) begin
                bready_cyc = cyc;
                if (!(aw_done && w_done)) proto_err++;
                for (int i = 0; i < b_delay && bready; i++) begin @(posedge clk); #1; end
                if (bready) begin
                    bvalid = 1; bresp = cfg_bresp; bid = 4'($urandom);
                    @(posedge clk); #1;
                    bvalid = 0; bresp = 2'($urandom); b_cnt++;
                    if (bready) proto_err++;
                end else if (!abort_ok) proto_err++;
            end
        end
    end

    initial begin
        arready = 0;
        forever begin
            @(posedge clk); #1;
            if (arvalid) begin
                for (int i = 0; i < ar_delay && arvalid; i++) begin @(posedge clk); #1; end
                if (arvalid) begin
                    arready = 1; got_araddr = araddr;
                    @(posedge clk); #1;
                    arready = 0; ar_cnt++;
                    if (arvalid) proto_err++;
                end else if (!abort_ok) proto_err++;
            end
        end
    end

    initial begin
        rvalid = 0; rresp = 0; rdata = 0; rid = 0; rlast = 0;
        forever begin
            @(posedge clk); #1;
            if (rready) begin
                for (int i = 0; i < r_delay && rready; i++) begin @(posedge clk); #1; end
                if (rready) begin
                    rvalid = 1; rdata = cfg_rdata; rresp = cfg_rresp; rlast = 1; rid = 4'($urandom);
                    @(posedge clk); #1;
                    rvalid = 0; rdata = $urandom; rresp = 2'($urandom); rlast = 0; r_cnt++;
                    if (rready) proto_err++;
                end else if (!abort_ok) proto_err++;
            end
        end
    end

    // txd decoder: sample mid-bit, record byte and the cycle its start bit began.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (txd === 1'b0 && rst === 1'b0) begin
                int unsigned t0;
                logic [7:0]  b;
                t0 = cyc;
                repeat (N / 2) begin @(posedge clk); #1; end
                if (txd !== 1'b0) tx_err++;
                for (int i = 0; i < 8; i++) begin
                    repeat (N) begin @(posedge clk); #1; end
                    b[i] = txd;
                end
                repeat (N) begin @(posedge clk); #1; end
                if (txd !== 1'b1) tx_err++;
                tx_q.push_back(b);
                tx_t.push_back(t0);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rxd = 0; wait_cyc(N);
        for (int i = 0; i < 8; i++) begin rxd = b[i]; wait_cyc(N); end
        rxd = stop_bit; wait_cyc(N);
        rxd = 1;
    endtask

    // One command/response exchange; expectations derive only from the command and slave response.
    task automatic run_txn(input string tag, input bit is_wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [1:0] resp,
                           input int awd, input int wd, input int ard, input int bd, input int rd);
        logic [7:0]  cmd[$];
        logic [7:0]  exp[$];
        logic [7:0]  status;
        int          aw0, w0, b0, ar0, r0, k;
        int unsigned last_hs;
        aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt; ar0 = ar_cnt; r0 = r_cnt;
        aw_done = 0; w_done = 0;
        aw_delay = awd; w_delay = wd; ar_delay = ard; b_delay = bd; r_delay = rd;
        cfg_bresp = resp; cfg_rresp = resp; cfg_rdata = data;
        tx_q.delete(); tx_t.delete();
        cmd.push_back(is_wr ? 8'h57 : 8'h52);
        for (int i = 3; i >= 0; i--) cmd.push_back(addr[i*8 +: 8]);
        if (is_wr) for (int i = 3; i >= 0; i--) cmd.push_back(data[i*8 +: 8]);
        status = (resp == 2'b00) ? 8'h4B : 8'h45;
        exp.push_back(status);
        if (!is_wr) for (int i = 3; i >= 0; i--) exp.push_back(data[i*8 +: 8]);
        foreach (cmd[i]) send_byte(cmd[i], 1'b1);
        k = 0;
        while (tx_q.size() < exp.size() && k < 2000) begin wait_cyc(1); k++; end
        check_eq({tag, "_reply_count"}, 64'(tx_q.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < tx_q.size(); i++) begin
            check_eq($sformatf("%s_reply%0d", tag, i), 64'(tx_q[i]), 64'(exp[i]));
            if (i > 0) check_eq($sformatf("%s_gap%0d", tag, i), 64'(tx_t[i] - tx_t[i-1]), 64'(10 * N));
        end
        if (is_wr) begin
            last_hs = (aw_hs_cyc > w_hs_cyc) ? aw_hs_cyc : w_hs_cyc;
            check_eq({tag, "_awaddr"}, 64'(got_awaddr), 64'(addr));
            check_eq({tag, "_wdata"}, 64'(got_wdata), 64'(data));
            check_eq({tag, "_aw_misc"}, 64'(got_aw_misc), 64'({4'd5, 8'd0, 3'b010, 2'b01}));
            check_eq({tag, "_w_misc"}, 64'(got_w_misc), 64'({4'hF, 1'b1}));
            check_eq({tag, "_xfers"}, 64'({aw_cnt - aw0, w_cnt - w0, b_cnt - b0, ar_cnt - ar0}),
                     64'({32'd1, 32'd1, 32'd1, 32'd0}) & 64'hFFFF_FFFF_FFFF_FFFF);
            check_eq({tag, "_bready_rise"}, 64'(bready_cyc), 64'(last_hs));
        end else begin
            check_eq({tag, "_araddr"}, 64'(got_araddr), 64'(addr));
            check_eq({tag, "_xfers"}, 64'({16'(ar_cnt - ar0), 16'(r_cnt - r0), 16'(aw_cnt - aw0)}),
                     64'({16'd1, 16'd1, 16'd0}));
        end
        check_eq({tag, "_proto"}, 64'(proto_err), 64'd0);
        check_eq({tag, "_txframe"}, 64'(tx_err), 64'd0);
        wait_cyc(N + 4);
    endtask

    initial begin
        int aw0, ar0, k;
        rst = 1; rxd = 0;
        wait_cyc(5);
        check_eq("rst_txd", 64'(txd), 64'd1);
        check_eq("rst_valids", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'd0);
        check_eq("rst_awaddr", 64'(awaddr), 64'd0);
        check_eq("rst_araddr", 64'(araddr), 64'd0);
        check_eq("rst_wdata", 64'(wdata), 64'd0);
        check_eq("const_aw", 64'({awid, awlen, awsize, awburst}), 64'({4'd5, 8'd0, 3'b010, 2'b01}));
        check_eq("const_ar", 64'({arid, arlen, arsize, arburst}), 64'({4'd5, 8'd0, 3'b010, 2'b01}));
        check_eq("const_w", 64'({wstrb, wlast}), 64'({4'hF, 1'b1}));
        // rxd held low through reset and past it must not yield any activity
        rst = 0;
        wait_cyc(3 * N);
        rxd = 1;
        wait_cyc(6 * N);
        check_eq("lowrst_activity", 64'({16'(aw_cnt), 16'(ar_cnt), 16'(tx_q.size())}), 64'd0);

        run_txn("wr_basic", 1, 32'h0000_1000, 32'hDEAD_BEEF, 2'd0, 0, 0, 0, 0, 0);
        run_txn("rd_basic", 0, 32'h0000_2004, 32'h1234_5678, 2'd0, 0, 0, 5, 0, 0);
        run_txn("wr_err", 1, 32'h0000_3000, 32'h0BAD_F00D, 2'd2, 1, 2, 0, 1, 0);
        run_txn("rd_err", 0, 32'h0000_4000, 32'h0000_0000, 2'd3, 0, 0, 0, 0, 2);
        run_txn("skew", 1, 32'h0000_5008, 32'hCAFE_0001, 2'd0, 3, 0, 0, 0, 0);
        check_eq("skew_order", 64'(aw_hs_cyc - w_hs_cyc), 64'd3);
        check_eq("skew_aw_held", 64'(w_saw_aw), 64'd1);

        // stray non-command byte
        aw0 = aw_cnt; ar0 = ar_cnt; tx_q.delete();
        send_byte(8'h41, 1'b1);
        wait_cyc(20 * N);
        check_eq("stray_activity", 64'({16'(aw_cnt - aw0), 16'(ar_cnt - ar0), 16'(tx_q.size())}), 64'd0);

        // start-bit glitch shortly before a real command
        rxd = 0; wait_cyc(2); rxd = 1; wait_cyc(N - 2);
        run_txn("glitch_rd", 0, 32'h8000_0010, 32'h5555_AAAA, 2'd0, 0, 0, 1, 0, 1);

        // framing error inside a partial command, then a full valid one
        aw0 = aw_cnt;
        send_byte(8'h57, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h10, 1'b0);
        wait_cyc(3 * N);
        check_eq("ferr_no_aw", 64'(aw_cnt - aw0), 64'd0);
        run_txn("ferr_wr", 1, 32'h57A5_0010, 32'h1122_3344, 2'd0, 0, 1, 0, 0, 0);

        // reset while a write is outstanding
        aw0 = aw_cnt; tx_q.delete();
        abort_ok = 1; aw_delay = 1000; w_delay = 1000;
        send_byte(8'h57, 1'b1);
        for (int i = 0; i < 8; i++) send_byte(8'(i + 1), 1'b1);
        k = 0;
        while (!awvalid && k < 100) begin wait_cyc(1); k++; end
        check_eq("rstmid_awvalid_seen", 64'(awvalid), 64'd1);
        wait_cyc(2);
        rst = 1; wait_cyc(1);
        check_eq("rstmid_valids", 64'({awvalid, wvalid, bready}), 64'd0);
        check_eq("rstmid_txd", 64'(txd), 64'd1);
        check_eq("rstmid_awaddr", 64'(awaddr), 64'd0);
        rst = 0;
        wait_cyc(3 * N);
        abort_ok = 0;
        check_eq("rstmid_no_reply", 64'({16'(aw_cnt - aw0), 16'(tx_q.size())}), 64'd0);
        run_txn("rstmid_rd", 0, 32'h0000_6000, 32'hFEED_FACE, 2'd0, 0, 0, 2, 0, 0);

        // randomized transactions
        for (int t = 0; t < 12; t++) begin
            bit         wr;
            logic [1:0] rs;
            wr = 1'($urandom_range(0, 1));
            rs = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            run_txn($sformatf("rnd%0d", t), wr, $urandom, $urandom, rs,
                    $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6),
                    $urandom_range(0, 6), $urandom_range(0, 6));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
